// File: rtl/stage2_collect.sv
// stage2_collect: result collector behind the three-stage stage2_add adder tree.
// Follows the en-gated adder pipeline to know when sum_in is a valid sum, then
// adds a per-map bias, saturates, optionally applies ReLU and buffers the result
// in a small FIFO that drains over a valid/ready stream with a last-of-map flag.
module stage2_collect #(
    parameter int DATA_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int OUT_PER_MAP = 25,
    parameter int RELU        = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] sum_in,
    input  logic signed [DATA_WIDTH-1:0] bias_in,
    input  logic                         bias_load,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam int CNT_W = (OUT_PER_MAP > 1) ? $clog2(OUT_PER_MAP) : 1;

    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_PER_MAP - 1);

    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Pipeline valid tracker, bias, framing counter and FIFO bookkeeping
    logic [2:0]            vpipe_q,    vpipe_d;
    logic [DATA_WIDTH-1:0] bias_q,     bias_d;
    logic [CNT_W-1:0]      map_cnt_q,  map_cnt_d;
    logic [PTR_W-1:0]      wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q,   rd_ptr_d;
    logic [OCC_W-1:0]      occ_q,      occ_d;
    logic                  overflow_q, overflow_d;

    // FIFO storage, data and last flag kept side by side per entry
    logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
    logic                  mem_last_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] wr_data_d;
    logic                  wr_last_d;

    // Datapath and handshake terms
    logic                  sample;
    logic [DATA_WIDTH:0]   sum_ext;
    logic [DATA_WIDTH-1:0] sum_sat;
    logic [DATA_WIDTH-1:0] result;
    logic                  is_last;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  pop;
    logic                  push;
    logic                  drop;

    // Bias add one bit wider than the operands, then clamp and optional ReLU
    always_comb begin
        sample  = vpipe_q[2];
        sum_ext = {sum_in[DATA_WIDTH-1], sum_in} + {bias_q[DATA_WIDTH-1], bias_q};
        sum_sat = sum_ext[DATA_WIDTH-1:0];
        if (sum_ext[DATA_WIDTH] != sum_ext[DATA_WIDTH-1]) begin
            sum_sat = sum_ext[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
        end
        result = sum_sat;
        if ((RELU != 0) && sum_sat[DATA_WIDTH-1]) begin
            result = '0;
        end
        is_last   = (map_cnt_q == CNT_LAST);
        wr_data_d = result;
        wr_last_d = is_last;
    end

    // FIFO handshake: a full FIFO still accepts a push when the head leaves on the same edge
    always_comb begin
        fifo_empty = (occ_q == '0);
        fifo_full  = (occ_q == OCC_FULL);
        pop        = !fifo_empty && out_ready;
        push       = sample && (!fifo_full || pop);
        drop       = sample && !push;
    end

    // Next-state for the tracker, bias, framing counter, pointers and sticky overflow
    always_comb begin
        vpipe_d = en ? {vpipe_q[1:0], 1'b1} : 3'b000;

        bias_d = bias_load ? bias_in : bias_q;

        map_cnt_d = map_cnt_q;
        if (sample) begin
            map_cnt_d = is_last ? '0 : map_cnt_q + 1'b1;
        end

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        overflow_d = overflow_q | drop;
    end

    // Control state register, cleared asynchronously so in-flight results are lost on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe_q    <= '0;
            bias_q     <= '0;
            map_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            vpipe_q    <= vpipe_d;
            bias_q     <= bias_d;
            map_cnt_q  <= map_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage needs no reset: outputs are masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= wr_data_d;
            mem_last_q[wr_ptr_q] <= wr_last_d;
        end
    end

    // Stream outputs present the FIFO head, forced to zero when nothing is queued
    always_comb begin
        out_valid = !fifo_empty;
        out_data  = '0;
        out_last  = 1'b0;
        if (!fifo_empty) begin
            out_data = mem_data_q[rd_ptr_q];
            out_last = mem_last_q[rd_ptr_q];
        end
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_stage2_collect.sv
// tb_stage2_collect: directed bench for stage2_collect. Two instances share all
// inputs, one with ReLU and one without, so both clamp paths are visible. Expected
// results are queued when stimulus is issued and popped by monitors on each handshake.
module tb_stage2_collect;

    localparam int W = 16;

    logic                clk       = 1'b0;
    logic                rst_n     = 1'b0;
    logic                en        = 1'b0;
    logic                bias_load = 1'b0;
    logic                out_ready = 1'b0;
    logic signed [W-1:0] sum_in    = '0;
    logic signed [W-1:0] bias_in   = '0;

    logic signed [W-1:0] out_data_a, out_data_b;
    logic                out_valid_a, out_valid_b;
    logic                out_last_a, out_last_b;
    logic                overflow_a, overflow_b;

    typedef struct packed {
        logic signed [W-1:0] data;
        logic                last;
    } exp_t;

    exp_t                sbA[$];
    exp_t                sbB[$];
    exp_t                popA, popB, pushTmp;
    logic signed [W-1:0] vals[$];
    logic signed [W-1:0] expA[$];
    logic signed [W-1:0] expB[$];
    bit                  keep[$];

    int total  = 0;
    int bad    = 0;
    int mapCnt = 0;

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    stage2_collect #(
        .DATA_WIDTH(16), .FIFO_DEPTH(8), .OUT_PER_MAP(25), .RELU(1)
    ) dut_relu (
        .clk(clk), .rst_n(rst_n), .en(en), .sum_in(sum_in), .bias_in(bias_in),
        .bias_load(bias_load), .out_data(out_data_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_last(out_last_a), .overflow(overflow_a)
    );

    stage2_collect #(
        .DATA_WIDTH(16), .FIFO_DEPTH(8), .OUT_PER_MAP(25), .RELU(0)
    ) dut_lin (
        .clk(clk), .rst_n(rst_n), .en(en), .sum_in(sum_in), .bias_in(bias_in),
        .bias_load(bias_load), .out_data(out_data_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_last(out_last_b), .overflow(overflow_b)
    );

    // Single comparison point: every check counts once and reports on mismatch
    task automatic checkOutput(input string name, input logic signed [31:0] actual,
                               input logic signed [31:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, actual, required, $time);
        end
    endtask

    // Monitor for the ReLU instance: on each accepted handshake compare head with scoreboard
    always @(negedge clk) begin
        if (rst_n && out_valid_a && out_ready) begin
            if (sbA.size() == 0) begin
                checkOutput("relu unexpected output", out_data_a, 0);
            end else begin
                popA = sbA.pop_front();
                checkOutput("relu data", out_data_a, popA.data);
                checkOutput("relu last", out_last_a, popA.last);
            end
        end
    end

    // Monitor for the pass-through instance, same handshake rule
    always @(negedge clk) begin
        if (rst_n && out_valid_b && out_ready) begin
            if (sbB.size() == 0) begin
                checkOutput("lin unexpected output", out_data_b, 0);
            end else begin
                popB = sbB.pop_front();
                checkOutput("lin data", out_data_b, popB.data);
                checkOutput("lin last", out_last_b, popB.last);
            end
        end
    end

    // Hard stop in case something stalls the main sequence
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        en = 1'b0;
        repeat (n) step();
    endtask

    task automatic loadBias(input logic signed [W-1:0] v);
        en        = 1'b0;
        bias_in   = v;
        bias_load = 1'b1;
        step();
        bias_load = 1'b0;
    endtask

    task automatic addVec(input logic signed [W-1:0] v, input logic signed [W-1:0] a,
                          input logic signed [W-1:0] b, input bit k);
        vals.push_back(v);
        expA.push_back(a);
        expB.push_back(b);
        keep.push_back(k);
    endtask

    // Queue the expected pair for one sample edge and advance the framing count
    task automatic expectSample(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                                input bit k);
        if (k) begin
            pushTmp.last = (mapCnt == 24);
            pushTmp.data = a;
            sbA.push_back(pushTmp);
            pushTmp.data = b;
            sbB.push_back(pushTmp);
        end
        mapCnt = (mapCnt == 24) ? 0 : mapCnt + 1;
    endtask

    // Drive a burst: en high for N+2 edges, samples on edges 4..N+3 carrying vals[]
    task automatic applyStimulus(input int readyEdge, input int biasEdge,
                                 input logic signed [W-1:0] biasVal);
        int n;
        n = vals.size();
        for (int e = 1; e <= n + 3; e++) begin
            en     = (e <= n + 2);
            sum_in = '0;
            if (e >= 4) begin
                sum_in = vals[e-4];
                expectSample(expA[e-4], expB[e-4], keep[e-4]);
            end
            if (readyEdge > 0) out_ready = (e == readyEdge);
            bias_in   = biasVal;
            bias_load = (e == biasEdge);
            step();
        end
        en        = 1'b0;
        bias_load = 1'b0;
        if (readyEdge > 0) out_ready = 1'b0;
        vals.delete();
        expA.delete();
        expB.delete();
        keep.delete();
    endtask

    task automatic doReset();
        checkOutput("relu scoreboard drained before reset", sbA.size(), 0);
        checkOutput("lin scoreboard drained before reset", sbB.size(), 0);
        sbA.delete();
        sbB.delete();
        en        = 1'b0;
        out_ready = 1'b0;
        bias_load = 1'b0;
        rst_n     = 1'b0;
        step();
        rst_n  = 1'b1;
        mapCnt = 0;
    endtask

    initial begin
        $display("[TB] stage2_collect bench start");

        // Reset state
        #12;
        checkOutput("reset out_valid", out_valid_a, 0);
        checkOutput("reset out_data", out_data_a, 0);
        checkOutput("reset out_last", out_last_a, 0);
        checkOutput("reset overflow", overflow_a, 0);
        step();
        rst_n = 1'b1;
        step();

        // Basic: bias 5, normal, negative and saturating sums
        loadBias(16'sd5);
        out_ready = 1'b1;
        addVec(16'sd10, 16'sd15, 16'sd15, 1'b1);
        addVec(-16'sd20, 16'sd0, -16'sd15, 1'b1);
        addVec(16'sd32767, 16'sd32767, 16'sd32767, 1'b1);
        applyStimulus(0, 0, '0);
        checkOutput("basic latency valid", out_valid_a, 1);
        checkOutput("basic latency data", out_data_a, 32767);
        idle(3);

        // Bias loaded on the sample edge: that sample still sees bias 5
        addVec(16'sd1, 16'sd6, 16'sd6, 1'b1);
        applyStimulus(0, 4, 16'sd100);
        addVec(16'sd1, 16'sd101, 16'sd101, 1'b1);
        applyStimulus(0, 0, 16'sd100);
        idle(3);

        // Enable gap: en 1,1,0,1,1,1 then a single sample on the following edge
        loadBias(-16'sd3);
        out_ready = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            en     = (e != 3) && (e != 7);
            sum_in = '0;
            if (e == 7) begin
                sum_in = -16'sd32767;
                expectSample(16'sd0, -16'sd32768, 1'b1);
            end
            step();
            if (e <= 6) checkOutput("gap no early sample", out_valid_a, 0);
        end
        en = 1'b0;
        idle(3);

        // Full FIFO with a simultaneous pop: the ninth push is accepted
        doReset();
        out_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            addVec(W'(k), W'(k), W'(k), 1'b1);
        end
        applyStimulus(12, 0, '0);
        checkOutput("full+pop overflow relu", overflow_a, 0);
        checkOutput("full+pop overflow lin", overflow_b, 0);

        // FIFO still holds 8, so one more sample without ready is dropped
        addVec(16'sd100, 16'sd100, 16'sd100, 1'b0);
        applyStimulus(0, 0, '0);
        checkOutput("overflow set", overflow_a, 1);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 7) checkOutput("valid before last pop", out_valid_a, 1);
        end
        checkOutput("valid after 8 pops", out_valid_a, 0);
        checkOutput("empty out_data", out_data_a, 0);
        checkOutput("overflow sticky", overflow_a, 1);
        idle(3);

        // Framing: 50 back-to-back samples, last on the 25th and 50th
        doReset();
        out_ready = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            addVec(W'(k), W'(k), W'(k), 1'b1);
        end
        applyStimulus(0, 0, '0);
        idle(3);

        // Backpressure: 26 samples, only 8 stored; dropped ones still advance framing
        doReset();
        out_ready = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            addVec(W'(k), W'(k), W'(k), k <= 8);
        end
        applyStimulus(0, 0, '0);
        checkOutput("backpressure overflow", overflow_a, 1);
        checkOutput("backpressure valid", out_valid_a, 1);
        out_ready = 1'b1;
        idle(10);
        checkOutput("backpressure drained", out_valid_a, 0);
        for (int k = 27; k <= 50; k++) begin
            addVec(W'(k), W'(k), W'(k), 1'b1);
        end
        applyStimulus(0, 0, '0);
        idle(3);

        // Reset mid-burst: 3 queued, tracker full, overflow set, bias 7
        loadBias(16'sd7);
        out_ready = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            en     = 1'b1;
            sum_in = 16'sd1;
            step();
        end
        checkOutput("pre-reset queued", out_valid_a, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("async reset out_valid", out_valid_a, 0);
        checkOutput("async reset out_data", out_data_a, 0);
        checkOutput("async reset out_last", out_last_a, 0);
        checkOutput("async reset overflow", overflow_a, 0);
        step();
        en     = 1'b0;
        rst_n  = 1'b1;
        mapCnt = 0;
        sbA.delete();
        sbB.delete();
        out_ready = 1'b1;
        addVec(16'sd40, 16'sd40, 16'sd40, 1'b1);
        applyStimulus(0, 0, '0);
        idle(3);

        checkOutput("relu scoreboard empty at end", sbA.size(), 0);
        checkOutput("lin scoreboard empty at end", sbB.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
